// File: rtl/if_pkg.sv
// ----------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction-fetch stage:
//   - FSM state encoding (S_FETCH, S_HOLD)
//   - NOP_INSTR, the word presented to IF/ID when no instruction is valid
//   - default RESET_PC / PC_INC values
//   - next_pc(): sequential PC advance (wraps modulo 2^32)
// ----------------------------------------------------------------------------
package if_pkg;

    localparam logic [0:0]  S_FETCH = 1'b0;  // request outstanding, waiting for ack
    localparam logic [0:0]  S_HOLD  = 1'b1;  // word parked in skid buffer, no request

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_PC_INC   = 32'd4;

    // Plain 32-bit add: 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
    function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] inc);
        return pc + inc;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// if_fetch_unit_if
// Instruction-memory request bus between the fetch unit and instruction memory.
//   imem_req   : fetch unit -> memory, request valid
//   imem_addr  : fetch unit -> memory, request address (the current pc)
//   imem_ack   : memory -> fetch unit, imem_rdata valid this cycle
//   imem_rdata : memory -> fetch unit, fetched instruction word
// Modports: master (fetch unit side), slave (memory side).
// ----------------------------------------------------------------------------
interface if_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/if_fetch_unit_skid_buf.sv
// ----------------------------------------------------------------------------
// if_skid_buf
// One-entry buffer holding a fetched word and its pc while IF/ID is stalled.
// Only instantiated when IF_SKID_BUF_EN is defined.
//   clock, reset       : clock, synchronous active-high reset
//   load               : capture load_data/load_pc, set valid
//   clear              : drop the entry (redirect)
//   unload             : entry consumed, clear valid
//   data, pc, valid    : buffered contents
// ----------------------------------------------------------------------------
module if_skid_buf (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic        unload,
    input  logic [31:0] load_data,
    input  logic [31:0] load_pc,
    output logic [31:0] data,
    output logic [31:0] pc,
    output logic        valid
);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            pc    <= load_pc;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage: owns the pc, issues instruction-memory requests and
// registers fetched words for the IF/ID pipeline register.
//   clock, reset  : clock, synchronous active-high reset
//   stall         : hazard unit hold; freezes outputs and pc
//   redirect      : taken branch/jump, highest priority; loads redirect_pc
//   redirect_pc   : redirect target
//   imem          : instruction-memory bus (master side)
//   instr_out     : instruction to IF/ID, NOP_INSTR when instr_valid=0
//   instr_valid   : instr_out is a real instruction
//   pc_out        : pc of instr_out
//   if_id_write   : IF/ID write enable, combinational ~stall
// Build option: define IF_SKID_BUF_EN to keep a word acked during a stall in
// a one-entry skid buffer instead of dropping and re-fetching it.
// ----------------------------------------------------------------------------
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_INC   = DEFAULT_PC_INC
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            instr_out,
    output logic                   instr_valid,
    output logic [31:0]            pc_out,
    output logic                   if_id_write
);

    logic [0:0]  state;
    logic [31:0] pc;

    // Request is gated by reset so nothing is issued during the reset cycle.
    assign imem.imem_req  = !reset && (state == S_FETCH);
    assign imem.imem_addr = pc;
    assign if_id_write    = !stall;

`ifdef IF_SKID_BUF_EN
    logic        skid_load;
    logic        skid_clear;
    logic        skid_unload;
    logic [31:0] skid_data;
    logic [31:0] skid_pc;
    logic        skid_valid;

    assign skid_load   = !reset && !redirect && (state == S_FETCH) && imem.imem_ack && stall;
    assign skid_clear  = redirect;
    assign skid_unload = !reset && !redirect && (state == S_HOLD) && !stall;

    if_skid_buf u_skid (
        .clock     (clock),
        .reset     (reset),
        .load      (skid_load),
        .clear     (skid_clear),
        .unload    (skid_unload),
        .load_data (imem.imem_rdata),
        .load_pc   (pc),
        .data      (skid_data),
        .pc        (skid_pc),
        .valid     (skid_valid)
    );
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            pc          <= RESET_PC;
            state       <= S_FETCH;
            instr_out   <= NOP_INSTR;
            instr_valid <= 1'b0;
            pc_out      <= '0;
        end else if (redirect) begin
            // Overrides stall and any ack arriving this cycle.
            pc          <= redirect_pc;
            state       <= S_FETCH;
            instr_out   <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else if (state == S_FETCH) begin
            if (imem.imem_ack && !stall) begin
                instr_out   <= imem.imem_rdata;
                pc_out      <= pc;
                instr_valid <= 1'b1;
                pc          <= next_pc(pc, PC_INC);
            end else if (imem.imem_ack) begin
`ifdef IF_SKID_BUF_EN
                // Word parked in the skid buffer; request stops until drained.
                pc    <= next_pc(pc, PC_INC);
                state <= S_HOLD;
`else
                // Word dropped; same address is requested again.
                pc    <= pc;
`endif
            end else if (!stall) begin
                instr_out   <= NOP_INSTR;
                instr_valid <= 1'b0;
            end
        end else begin
`ifdef IF_SKID_BUF_EN
            if (!stall && skid_valid) begin
                instr_out   <= skid_data;
                pc_out      <= skid_pc;
                instr_valid <= 1'b1;
                state       <= S_FETCH;
            end
`else
            state <= S_FETCH;
`endif
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_unit
// Self-checking bench for if_fetch_unit. The bench plays instruction memory
// (rdata = addr ^ 32'hA5A5_0000) and keeps a cycle-level reference of the
// visible fetch behaviour: a pc, the last word handed to IF/ID, and a queue
// for a word parked during a stall (skid build only).
// ----------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] INC    = 32'd4;

    logic        clock = 1'b0;
    logic        reset, stall, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_out, pc_out;
    logic        instr_valid, if_id_write;

    int n_checks = 0;
    int n_errors = 0;

    // reference state
    logic [31:0] m_pc, m_out, m_pcout;
    logic        m_valid;
    logic [31:0] held_d[$];
    logic [31:0] held_p[$];

    always #5 clock = ~clock;

    if_fetch_unit_if imem ();

    if_fetch_unit #(.RESET_PC(RST_PC), .PC_INC(INC)) dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem.master),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .pc_out      (pc_out),
        .if_id_write (if_id_write)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: check registered outputs, apply inputs, check combinational
    // outputs, then advance the reference across the coming edge.
    task automatic step(input bit r, input bit s, input bit rd,
                        input logic [31:0] rpc, input bit ack_en);
        bit          req, a;
        logic [31:0] d;
        @(negedge clock);
        chk("instr_out",   instr_out,   m_out);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
        chk("pc_out",      pc_out,      m_pcout);
        reset       = r;
        stall       = s;
        redirect    = rd;
        redirect_pc = rpc;
        req = !r && (held_d.size() == 0);
        // during reset an ack is offered anyway: it must be ignored
        a   = ack_en && (req || r);
        d   = m_pc ^ 32'hA5A5_0000;
        imem.imem_ack   = a;
        imem.imem_rdata = a ? d : $urandom;
        #1;
        chk("imem_req",    {31'b0, imem.imem_req}, {31'b0, req});
        if (req) chk("imem_addr", imem.imem_addr, m_pc);
        chk("if_id_write", {31'b0, if_id_write}, {31'b0, !s});
        if (r) begin
            m_pc = RST_PC; m_out = 0; m_valid = 0; m_pcout = 0;
            held_d.delete(); held_p.delete();
        end else if (rd) begin
            m_pc = rpc; m_out = 0; m_valid = 0;
            held_d.delete(); held_p.delete();
        end else if (held_d.size() != 0) begin
            if (!s) begin
                m_out = held_d.pop_front(); m_pcout = held_p.pop_front(); m_valid = 1;
            end
        end else if (a && !s) begin
            m_out = d; m_pcout = m_pc; m_valid = 1; m_pc = m_pc + INC;
        end else if (a && s) begin
`ifdef IF_SKID_BUF_EN
            held_d.push_back(d); held_p.push_back(m_pc); m_pc = m_pc + INC;
`endif
        end else if (!s) begin
            m_out = 0; m_valid = 0;
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem.imem_ack = 1'b0; imem.imem_rdata = '0;
        m_pc = RST_PC; m_out = 0; m_pcout = 0; m_valid = 0;
        @(posedge clock);

        // reset two cycles, then ack every cycle
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);

        // ack every third cycle
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, (i % 3) == 2);

        // stall three cycles at pc=0x10 while memory acks
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

        // redirect in the same cycle as the ack of 0x20
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);
        step(0, 0, 1, 32'h100, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

        // redirect together with stall
        step(0, 1, 1, 32'h100, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

        // pc wrap
        step(0, 0, 1, 32'hFFFF_FFFC, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

        // reset mid-request
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 8,
                 {$urandom_range(0, 32'h3FFF), 2'b00},
                 $urandom_range(0, 99) < 60);
        end
        step(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
